// File: rtl/mem_responder.sv
// Serial-symbol memory slave: decodes read16/write16/write8 messages on tx_pins,
// answers reads on rx_pins after a configurable gap, and accepts host preloads while idle.
module mem_responder #(
  parameter int unsigned ADDR_BITS  = 6,
  parameter int unsigned RESP_DELAY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           tx_pins,
  output logic [1:0]           rx_pins,
  input  logic                 load_en,
  input  logic [ADDR_BITS-2:0] load_addr,
  input  logic [15:0]          load_data,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned WORDS = 1 << (ADDR_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {M_RD = 2'b01, M_WR16 = 2'b10, M_WR8 = 2'b11} msg_e;

  state_e               state_q;
  msg_e                 msg_q;
  logic [3:0]           cnt_q;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [13:0]          data_q;
  logic [15:0]          resp_q;
  logic [1:0]           rx_q;
  logic                 busy_q;
  logic                 ovr_q;
  logic [15:0]          mem_q [WORDS];

  logic                 we;
  logic [1:0]           wbe;
  logic [ADDR_BITS-2:0] widx;
  logic [15:0]          wdata;

  // Symbol k lands on address bits [2k+1:2k]; symbols beyond ADDR_BITS are dropped.
  always_comb begin
    addr_d = addr_q;
    for (int unsigned b = 0; b < ADDR_BITS; b++) begin
      if ((b >> 1) == 32'(cnt_q)) addr_d[b] = tx_pins[b[0]];
    end
  end

  always_comb begin
    we    = 1'b0;
    wbe   = 2'b11;
    widx  = load_addr;
    wdata = load_data;
    if (state_q == S_IDLE && load_en) begin
      we = 1'b1;
    end else if (state_q == S_DATA) begin
      if (msg_q == M_WR16 && cnt_q == 4'd7) begin
        we    = 1'b1;
        widx  = addr_q[ADDR_BITS-1:1];
        wdata = {tx_pins, data_q};
      end else if (msg_q == M_WR8 && cnt_q == 4'd3) begin
        we    = 1'b1;
        widx  = addr_q[ADDR_BITS-1:1];
        wdata = {2{tx_pins, data_q[13:8]}};
        wbe   = addr_q[0] ? 2'b10 : 2'b01;
      end
    end
  end

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wbe[0]) mem_q[widx][7:0]  <= wdata[7:0];
      if (wbe[1]) mem_q[widx][15:8] <= wdata[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      msg_q   <= M_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_pins != 2'b00) begin
            msg_q   <= msg_e'(tx_pins);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          addr_q <= addr_d;
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_q <= '0;
            if (msg_q == M_RD) begin
              // Snapshot the word now so later writes cannot change the reply.
              resp_q <= mem_q[addr_d[ADDR_BITS-1:1]];
              if (RESP_DELAY == 0) begin
                rx_q    <= 2'b01;
                state_q <= S_RESP;
              end else begin
                state_q <= S_WAIT;
              end
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          data_q <= {tx_pins, data_q[13:2]};
          cnt_q  <= cnt_q + 4'd1;
          if ((msg_q == M_WR16 && cnt_q == 4'd7) || (msg_q == M_WR8 && cnt_q == 4'd3)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (tx_pins != 2'b00) ovr_q <= 1'b1;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(RESP_DELAY - 1)) begin
            cnt_q   <= '0;
            rx_q    <= 2'b01;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_pins != 2'b00) ovr_q <= 1'b1;
          if (cnt_q == 4'd8) begin
            rx_q    <= 2'b00;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rx_q   <= resp_q[1:0];
            resp_q <= {2'b00, resp_q[15:2]};
            cnt_q  <= cnt_q + 4'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_pins = rx_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6: number of byte-address bits decoded; memory holds 2^(ADDR_BITS-1) 16-bit words.
REQ-002 SHALL have parameter RESP_DELAY, default 1: idle cycles between the last address symbol and the response start symbol; legal range 0..7.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_pins  input  2  CPU-to-memory symbol stream; 2'b00 is idle.
REQ-006 SHALL have port rx_pins  output  2  memory-to-CPU symbol stream, registered; 2'b00 is idle.
REQ-007 SHALL have port load_en  input  1  host preload strobe.
REQ-008 SHALL have port load_addr  input  ADDR_BITS-1  host preload word index.
REQ-009 SHALL have port load_data  input  16  host preload word.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port overrun  output  1  sticky flag: header received while not IDLE.

Function
REQ-012 SHALL use states IDLE, ADDR, DATA, WAIT, RESP; cycle numbers below count from the cycle whose edge samples the header (cycle 0).
REQ-013 In IDLE, a nonzero tx_pins sample SHALL be latched as message type: 01 read16, 10 write16, 11 write8; next state ADDR.
REQ-014 ADDR SHALL sample 8 symbols in cycles 1..8, LSB first, symbol k giving address bits [2k+1:2k]; bits above ADDR_BITS-1 ignored.
REQ-015 Word index SHALL be addr[ADDR_BITS-1:1]; addr[0] selects the byte lane for write8 and is ignored otherwise.
REQ-016 For write16, DATA SHALL sample 8 symbols in cycles 9..16, LSB first; the word SHALL be written at the edge sampling cycle 16; then IDLE.
REQ-017 For write8, DATA SHALL sample 4 symbols in cycles 9..12; only the addressed byte lane SHALL be written, at the edge sampling cycle 12; then IDLE.
REQ-018 For read16, the addressed word SHALL be captured at the edge sampling cycle 8; later writes or loads SHALL NOT alter the returned value.
REQ-019 For read16, rx_pins SHALL be 00 in WAIT for RESP_DELAY cycles, 01 (start) in cycle 9+RESP_DELAY, then 8 data symbols LSB first in cycles 10+RESP_DELAY..17+RESP_DELAY, then 00.
REQ-020 A new header SHALL be accepted no earlier than the cycle after the last data symbol (read) or the last write-data symbol (write).
REQ-021 A nonzero tx_pins during WAIT or RESP SHALL set overrun and SHALL otherwise be ignored; nonzero symbols during ADDR/DATA are payload.
REQ-022 load_en in IDLE SHALL write load_data to load_addr at that edge; a simultaneous header SHALL still be accepted.
REQ-023 load_en while busy SHALL be ignored without side effects.
REQ-024 A message write and load to the same word never coincide (load ignored while busy).

Reset
REQ-025 Asserting rst_n low SHALL immediately force IDLE, rx_pins=00, busy=0, overrun=0, regardless of state, including mid-message.
REQ-026 Memory contents SHALL NOT be reset and SHALL be retained across reset.
REQ-027 After deassertion, the first header SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-028 Preload word 3 = 16'hA55A; read16 of address 16'h0006 -> rx 01 in cycle 10, symbols 2,2,1,1,1,1,2,2 in cycles 11..18, busy low in cycle 19.
REQ-029 write16 16'h1234 to address 16'h0010, then read16 of 16'h0010 -> 16'h1234 returned; overrun stays 0.
REQ-030 Preload word 2 = 16'hFFFF; write8 8'h00 to address 16'h0005 -> subsequent read of 16'h0004 returns 16'h00FF.
REQ-031 Header 01 driven in cycle 12 during WAIT/RESP of a read -> overrun=1 and sticky, response unchanged, no second response.
REQ-032 rst_n pulsed low in cycle 13 of a read -> rx_pins 00 at once, busy 0, overrun 0; immediate new read returns correct data; preloaded memory retained.
REQ-033 RESP_DELAY=0 and RESP_DELAY=7 builds -> start symbol in cycles 9 and 16 respectively; back-to-back reads with header in the first legal cycle both served.
